// File: rtl/pc_sequencer.sv
// Multicycle control FSM for the MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB,
// selects the PC source, emits datapath strobes and counts retired instructions.
module pc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             known_op;
    logic             is_jr;
    logic             is_sw;

    always_comb begin
        case (opcode)
            6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001010, 6'b000100, 6'b000101, 6'b100011, 6'b101011: known_op = 1'b1;
            default:                                             known_op = 1'b0;
        endcase
    end

    assign is_jr = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_sw = (opcode == OP_SW);

    // NOTE: every output and state_d gets a default before the case, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        illegal  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!stall) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (!stall && imem_ready) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!stall) begin
                    if (opcode == OP_J) begin
                        pc_en   = 1'b1;
                        pc_sel  = 2'd2;
                        state_d = FETCH;
                    end else if (is_jr) begin
                        pc_en   = 1'b1;
                        pc_sel  = 2'd3;
                        state_d = FETCH;
                    end else if (known_op) begin
                        state_d = EXEC;
                    end else begin
                        // Unknown opcode retires as a NOP so the core keeps running.
                        illegal = 1'b1;
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (opcode == OP_BEQ) begin
                        pc_en   = 1'b1;
                        pc_sel  = {1'b0, zero};
                        state_d = FETCH;
                    end else if (opcode == OP_BNE) begin
                        pc_en   = 1'b1;
                        pc_sel  = {1'b0, ~zero};
                        state_d = FETCH;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state_d = MEM;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            MEM: begin
                // The request stays up through a stall so the memory keeps its
                // transaction; only the write strobe and the handshake are frozen.
                dmem_req = 1'b1;
                if (!stall) begin
                    dmem_we = is_sw;
                    if (dmem_ready) begin
                        if (is_sw) begin
                            pc_en   = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end
                end
            end
            WB: begin
                if (!stall) begin
                    reg_we  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, pc_en};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a route-per-instruction-class reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pc_sequencer;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             stall;
    logic             imem_req;
    logic             ir_load;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic             pc_en;
    logic [1:0]       pc_sel;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    pc_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .stall      (stall),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_we     (reg_we),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instruction class walks a fixed route of phases (codes = state codes).
    // A phase finishes when not stalled and, for FETCH/MEM, when memory is ready.
    // Leaving the last phase of the route retires the instruction.
    typedef enum int {C_J, C_JR, C_ILL, C_BEQ, C_BNE, C_ALU, C_LW, C_SW} cls_e;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_load;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_we;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       illegal;
    } exp_t;

    typedef struct {
        int cyc;
        int nreq;
        int nwe;
        int nreg;
        int npc;
        int nill;
        int sel;
    } stats_t;

    bit               m_idle = 1'b1;
    int               m_pos  = 0;
    logic [CNT_W-1:0] m_ret  = '0;

    function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000010: return C_J;
            6'b000000: return (fn == 6'b001000) ? C_JR : C_ALU;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010: return C_ALU;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int route_len(input cls_e c);
        case (c)
            C_BEQ, C_BNE: return 3;
            C_SW, C_ALU:  return 4;
            C_LW:         return 5;
            default:      return 2;
        endcase
    endfunction

    function automatic int route_phase(input cls_e c, input int pos);
        int r[5];
        case (c)
            C_BEQ, C_BNE: r = '{1, 2, 3, 0, 0};
            C_SW:         r = '{1, 2, 3, 4, 0};
            C_LW:         r = '{1, 2, 3, 4, 5};
            C_ALU:        r = '{1, 2, 3, 5, 0};
            default:      r = '{1, 2, 0, 0, 0};
        endcase
        return r[pos];
    endfunction

    function automatic bit phase_done(input int p);
        if (stall) return 1'b0;
        if (p == 1) return imem_ready;
        if (p == 4) return dmem_ready;
        return 1'b1;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        cls_e c;
        int   p;
        bit   go;
        bit   fin;
        e = '0;
        if (m_idle) return e;
        c   = classify(opcode, funct);
        p   = route_phase(c, m_pos);
        go  = phase_done(p);
        fin = go && (m_pos == route_len(c) - 1);
        e.state    = 3'(p);
        e.imem_req = (p == 1);
        e.dmem_req = (p == 4);
        e.ir_load  = (p == 1) && go;
        e.dmem_we  = (p == 4) && (c == C_SW) && !stall;
        e.reg_we   = (p == 5) && go;
        e.illegal  = (p == 2) && (c == C_ILL) && go;
        e.pc_en    = fin;
        if (fin) begin
            case (c)
                C_J:     e.pc_sel = 2'd2;
                C_JR:    e.pc_sel = 2'd3;
                C_BEQ:   e.pc_sel = zero ? 2'd1 : 2'd0;
                C_BNE:   e.pc_sel = zero ? 2'd0 : 2'd1;
                default: e.pc_sel = 2'd0;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle <= 1'b1;
            m_pos  <= 0;
            m_ret  <= '0;
        end else if (m_idle) begin
            if (!stall) begin
                m_idle <= 1'b0;
                m_pos  <= 0;
            end
        end else if (phase_done(route_phase(classify(opcode, funct), m_pos))) begin
            if (m_pos == route_len(classify(opcode, funct)) - 1) begin
                m_pos <= 0;
                m_ret <= m_ret + 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Compare process: every cycle, mid-low-phase, after inputs have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        e = expect_now();
        check("state",    int'(state),    int'(e.state));
        check("imem_req", int'(imem_req), int'(e.imem_req));
        check("ir_load",  int'(ir_load),  int'(e.ir_load));
        check("dmem_req", int'(dmem_req), int'(e.dmem_req));
        check("dmem_we",  int'(dmem_we),  int'(e.dmem_we));
        check("reg_we",   int'(reg_we),   int'(e.reg_we));
        check("pc_en",    int'(pc_en),    int'(e.pc_en));
        check("pc_sel",   int'(pc_sel),   int'(e.pc_sel));
        check("illegal",  int'(illegal),  int'(e.illegal));
        check("retired",  int'(retired),  int'(m_ret));
    end

    // ---------------- directed helpers ----------------
    // Called mid-cycle while the DUT sits in FETCH; runs one instruction with
    // zero-wait fetch and `waits` MEM wait cycles, returns when FETCH is re-entered.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int waits, output stats_t s);
        int mseen;
        bit done;
        s = '{default: 0};
        mseen = 0;
        done  = 1'b0;
        opcode = op; funct = fn; zero = z;
        imem_ready = 1'b1; dmem_ready = 1'b0; stall = 1'b0;
        #1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (i > 0) begin
                @(negedge clk);
                dmem_ready = (state == 3'd4) && (mseen >= waits);
                #3;
                done = (state == 3'd1);
            end
            if (!done) begin
                s.cyc++;
                if (dmem_req) s.nreq++;
                if (dmem_we)  s.nwe++;
                if (reg_we)   s.nreg++;
                if (illegal)  s.nill++;
                if (pc_en) begin
                    s.npc++;
                    s.sel = int'(pc_sel);
                end
                if (state == 3'd4) mseen++;
            end
        end
        check("instr_done", int'(done), 1);
    endtask

    logic [5:0] pool [14] = '{6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101,
                              6'b001010, 6'b000100, 6'b000101, 6'b100011, 6'b101011,
                              6'b000010, 6'b111111, 6'b010000, 6'b100011};

    initial begin
        stats_t s;
        int     seq[5];
        bit     found;

        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; stall = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        #3;
        check("rst_state",    int'(state),    0);
        check("rst_retired",  int'(retired),  0);
        check("rst_imem_req", int'(imem_req), 0);

        // addi: 0 -> 1 -> 2 -> 3 -> 5 -> 1, one retire in WB.
        @(negedge clk);
        rst = 1'b1; opcode = 6'b001000; funct = '0; imem_ready = 1'b1;
        #3;
        check("rel_state_idle", int'(state), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #3;
            seq[k] = int'(state);
            if (k == 3) begin
                check("addi_wb_pc_en",  int'(pc_en),  1);
                check("addi_wb_reg_we", int'(reg_we), 1);
                check("addi_wb_pc_sel", int'(pc_sel), 0);
            end
        end
        check("addi_seq0", seq[0], 1);
        check("addi_seq1", seq[1], 2);
        check("addi_seq2", seq[2], 3);
        check("addi_seq3", seq[3], 5);
        check("addi_seq4", seq[4], 1);
        check("addi_retired", int'(retired), 1);

        // beq taken, then beq not taken.
        run_instr(6'b000100, 6'b0, 1'b1, 0, s);
        check("beq_t_cycles", s.cyc, 3);
        check("beq_t_sel",    s.sel, 1);
        check("beq_t_npc",    s.npc, 1);
        run_instr(6'b000100, 6'b0, 1'b0, 0, s);
        check("beq_n_cycles", s.cyc, 3);
        check("beq_n_sel",    s.sel, 0);
        check("beq_retired",  int'(retired), 3);

        // lw with three MEM wait cycles.
        run_instr(6'b100011, 6'b0, 1'b0, 3, s);
        check("lw_cycles",   s.cyc,  8);
        check("lw_dmem_req", s.nreq, 4);
        check("lw_dmem_we",  s.nwe,  0);
        check("lw_reg_we",   s.nreg, 1);
        check("lw_npc",      s.npc,  1);

        // j, jr, illegal.
        run_instr(6'b000010, 6'b0, 1'b0, 0, s);
        check("j_cycles", s.cyc, 2);
        check("j_sel",    s.sel, 2);
        check("j_ill",    s.nill, 0);
        run_instr(6'b000000, 6'b001000, 1'b0, 0, s);
        check("jr_cycles", s.cyc, 2);
        check("jr_sel",    s.sel, 3);
        check("jr_ill",    s.nill, 0);
        run_instr(6'b111111, 6'b0, 1'b0, 0, s);
        check("ill_cycles", s.cyc, 2);
        check("ill_sel",    s.sel, 0);
        check("ill_pulse",  s.nill, 1);
        check("ill_npc",    s.npc, 1);
        check("jjr_retired", int'(retired), 7);

        // sw stalled for two MEM cycles while dmem_ready is already high.
        opcode = 6'b101011; funct = '0; imem_ready = 1'b1; dmem_ready = 1'b1; stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #3;
            found = (state == 3'd4);
        end
        check("sw_reach_mem", int'(found), 1);
        stall = 1'b1;
        #1;
        check("sw_stall_we",   int'(dmem_we),  0);
        check("sw_stall_pc",   int'(pc_en),    0);
        check("sw_stall_req",  int'(dmem_req), 1);
        @(negedge clk);
        #3;
        check("sw_stall2_state", int'(state),   4);
        check("sw_stall2_we",    int'(dmem_we), 0);
        @(negedge clk);
        stall = 1'b0;
        #3;
        check("sw_go_state", int'(state),   4);
        check("sw_go_we",    int'(dmem_we), 1);
        check("sw_go_pc",    int'(pc_en),   1);
        @(negedge clk);
        #3;
        check("sw_fetch",   int'(state),   1);
        check("sw_retired", int'(retired), 8);

        // Seven more retires reach all-ones; the next one wraps.
        for (int i = 0; i < 7; i++) run_instr(6'b000010, 6'b0, 1'b0, 0, s);
        check("ret_allones", int'(retired), 15);
        run_instr(6'b000010, 6'b0, 1'b0, 0, s);
        check("ret_wrap", int'(retired), 0);

        // Reset asserted mid-MEM aborts the load.
        opcode = 6'b100011; dmem_ready = 1'b0; imem_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #3;
            found = (state == 3'd4);
        end
        check("lw_reach_mem", int'(found), 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_state",    int'(state),    0);
        check("arst_dmem_req", int'(dmem_req), 0);
        check("arst_imem_req", int'(imem_req), 0);
        check("arst_pc_en",    int'(pc_en),    0);
        check("arst_retired",  int'(retired),  0);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic, one mid-run reset; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) rst = 1'b0;
            if (c == 1502) rst = 1'b1;
            if (state == 3'd0 || state == 3'd1) begin
                opcode = pool[$urandom_range(0, 13)];
                funct  = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'($urandom);
            end
            zero       = 1'($urandom);
            imem_ready = ($urandom_range(0, 9) < 7);
            dmem_ready = ($urandom_range(0, 9) < 6);
            stall      = ($urandom_range(0, 9) < 2);
        end

        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
